aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encrypt round sequencer around one shared 128-bit AddRoundKey XOR.
//  Accepts a plaintext block and steps the state register through NR rounds.
//  Selects the round key by index and routes round-function outputs into the XOR.
//  Returns the ciphertext over a valid/ready handshake.
//  Sits between the block I/O and the combinational round logic (SubBytes/ShiftRows/MixColumns) plus the key store.
// PARAMETERS
//  NR       10  number of rounds (10/12/14 for AES-128/192/256)
//  RIDX_W    4  width of round-key index; must hold NR
// PORTS
//  clk          in   1    sole clock, rising edge
//  rst_n        in   1    synchronous active-low reset
//  in_valid     in   1    plaintext offered
//  in_ready     out  1    controller can accept plaintext
//  in_data      in   128  plaintext block
//  out_valid    out  1    ciphertext available
//  out_ready    in   1    consumer takes ciphertext
//  out_data     out  128  ciphertext; equals state register
//  rk_idx       out  RIDX_W  round-key index presented to key store
//  rk           in   128  round key for rk_idx, same cycle (combinational store read)
//  rf_state     out  128  current state register, fed to round logic
//  rf_mix       in   128  MixColumns(ShiftRows(SubBytes(rf_state)))
//  rf_final     in   128  ShiftRows(SubBytes(rf_state)), no MixColumns
//  busy         out  1    high in INIT..FINAL phases (any state but IDLE/DONE)
// BEHAVIOUR
//  Reset values
//   - Reset is synchronous and active-low; every reset value below applies on a clk edge with rst_n=0.
//   - fsm=IDLE, round=0, state=0, out_valid=0, busy=0.
//   - in_ready=1 one cycle after reset release.
//   - Reset mid-operation: the block is discarded, nothing is emitted, fsm returns to IDLE.
//  FSM states
//   - IDLE: in_ready=1, rk_idx=0.
//       On in_valid: state<=in_data^rk, round<=1, go ROUND (NR>1).
//   - ROUND: rk_idx=round.
//       Each cycle: state<=rf_mix^rk, round<=round+1.
//       When round==NR-1 go FINAL.
//   - FINAL: rk_idx=NR. state<=rf_final^rk, go DONE.
//   - DONE: out_valid=1, out_data stable.
//       On out_ready: out_valid<=0, go IDLE.
//  Handshake rules
//   - in_ready=(fsm==IDLE) exactly; in_valid outside IDLE is ignored, no buffering.
//   - out_valid/out_data hold until accepted.
//   - Transfer only on valid&ready at the clk edge.
//  Latency
//   - Acceptance edge = cycle 0.
//   - out_valid rises after NR further edges (NR=10: cycle 10); back-to-back throughput is one block per NR+2 cycles.
//   - One IDLE bubble after each output handshake: no same-cycle out-accept/in-accept overlap.
//  Arithmetic and signals
//   - All XORs are plain bitwise 128-bit; round counter is RIDX_W bits and never wraps (max NR).
//   - rk_idx is driven in every state; it is 0 in DONE.
//   - rf_state = state register at all times.
// STRUCTURE
//  - Shared package aes_pkg: NR_AES128/192/256 constants, fsm enum {IDLE,ROUND,FINAL,DONE}, 128-bit block typedef.
//  - Sub-modules: one add128 instance (existing) for the single shared XOR.
//  - The XOR input is muxed among in_data, rf_mix and rf_final by fsm.
//  - FSM, counter and state register are in this module.
// TESTING
//  - FIPS-197 C.1, bench models round logic + key store.
//      pt=00112233445566778899aabbccddeeff, key=000102..0f
//      -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 cycles after accept.
//  - rk_idx trace for one block:
//      -> 0 at accept, then 1..9 in ROUND, 10 in FINAL, 0 in DONE; each index used exactly once.
//  - Backpressure: out_ready low 5 cycles in DONE, in_valid high throughout
//      -> out_data stable, in_ready=0, no second accept until handshake+1 cycle.
//  - Reset mid-operation: rst_n=0 at round 4, then a new pt
//      -> out_valid never pulses for the aborted block; new block yields its correct ciphertext.
//  - NR=14 build with FIPS-197 C.3 vector
//      -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
//  - Back-to-back two blocks, out_ready tied 1
//      -> accepts spaced NR+2=12 cycles; both outputs correct in order.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round counts per key size, controller FSM states, block type.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;
    localparam int unsigned BLK_W     = 128;

    typedef logic [BLK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } fsm_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block I/O bundle: plaintext in and ciphertext out, each with a valid/ready pair.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t in_data;
    logic   out_valid;
    logic   out_ready;
    block_t out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/add128.sv
// 128-bit GF(2) addition, i.e. the AddRoundKey XOR.
module add128
    import aes_pkg::*;
(
    input  block_t a,
    input  block_t b,
    output block_t y
);

    assign y = a ^ b;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES encrypt round sequencer: one shared AddRoundKey XOR, external round
// logic and key store, valid/ready block I/O.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR     = NR_AES128,
    parameter int unsigned RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_round_ctrl_if.slave   blk,
    output logic [RIDX_W-1:0] rk_idx,
    input  block_t            rk,
    output block_t            rf_state,
    input  block_t            rf_mix,
    input  block_t            rf_final,
    output logic              busy
);

    fsm_e              fsm;
    logic [RIDX_W-1:0] round;
    block_t            state;
    block_t            xor_a;
    block_t            xor_y;
    logic              last_round;

    assign last_round   = (round == RIDX_W'(NR - 1));
    assign rf_state     = state;
    assign blk.out_data = state;

    // Route whichever operand the current phase needs into the shared XOR.
    always_comb begin
        xor_a = rf_final;
        case (fsm)
            IDLE:    xor_a = blk.in_data;
            ROUND:   xor_a = rf_mix;
            default: xor_a = rf_final;
        endcase
    end

    add128 u_add (
        .a (xor_a),
        .b (rk),
        .y (xor_y)
    );

    // rk_idx is registered one step ahead so the key store sees the index of the current phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm           <= IDLE;
            round         <= '0;
            state         <= '0;
            rk_idx        <= '0;
            busy          <= 1'b0;
            blk.in_ready  <= 1'b0;
            blk.out_valid <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (blk.in_valid && blk.in_ready) begin
                        state        <= xor_y;
                        round        <= RIDX_W'(1);
                        rk_idx       <= RIDX_W'(1);
                        busy         <= 1'b1;
                        blk.in_ready <= 1'b0;
                        fsm          <= ROUND;
                    end else begin
                        blk.in_ready <= 1'b1;
                    end
                end
                ROUND: begin
                    state  <= xor_y;
                    round  <= round + RIDX_W'(1);
                    rk_idx <= round + RIDX_W'(1);
                    if (last_round) begin
                        fsm <= FINAL;
                    end
                end
                FINAL: begin
                    state         <= xor_y;
                    rk_idx        <= '0;
                    busy          <= 1'b0;
                    blk.out_valid <= 1'b1;
                    fsm           <= DONE;
                end
                DONE: begin
                    if (blk.out_ready) begin
                        blk.out_valid <= 1'b0;
                        blk.in_ready  <= 1'b1;
                        round         <= '0;
                        fsm           <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: AES-128 and AES-256 builds driven by a behavioural round
// function and key store, checked against FIPS-197 vectors.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam block_t PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam block_t CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam block_t CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam block_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam block_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus10 ();
    aes_round_ctrl_if bus14 ();

    logic [3:0] rk_idx10, rk_idx14;
    block_t     rk10, rk14, rf_state10, rf_state14;
    block_t     rf_mix10, rf_mix14, rf_final10, rf_final14;
    logic       busy10, busy14;

    logic [7:0] sbox_t [0:255];
    block_t     ks [0:2][0:15];
    int         sel10 = 0;
    int         vectors = 0;
    int         miscompares = 0;
    int         acc10 = 0;

    aes_round_ctrl #(.NR(NR_AES128), .RIDX_W(4)) dut10 (
        .clk(clk), .rst_n(rst_n), .blk(bus10), .rk_idx(rk_idx10), .rk(rk10),
        .rf_state(rf_state10), .rf_mix(rf_mix10), .rf_final(rf_final10), .busy(busy10)
    );

    aes_round_ctrl #(.NR(NR_AES256), .RIDX_W(4)) dut14 (
        .clk(clk), .rst_n(rst_n), .blk(bus14), .rk_idx(rk_idx14), .rk(rk14),
        .rf_state(rf_state14), .rf_mix(rf_mix14), .rf_final(rf_final14), .busy(busy14)
    );

    // ---------------- AES reference pieces ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Byte i sits at [127-8i -: 8]; state is column-major, so byte i is row i%4, column i/4.
    function automatic block_t sub_shift(input block_t s);
        block_t o;
        int     src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (((i / 4) + (i % 4)) % 4) * 4 + (i % 4);
            o[127 - 8*i -: 8] = sbox_t[s[127 - 8*src -: 8]];
        end
        return o;
    endfunction

    function automatic block_t mix(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
            o[103 - 32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    task automatic expand(input int set, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) ks[set][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    assign rf_final10 = sub_shift(rf_state10);
    assign rf_mix10   = mix(rf_final10);
    assign rf_final14 = sub_shift(rf_state14);
    assign rf_mix14   = mix(rf_final14);
    assign rk10       = ks[sel10][rk_idx10];
    assign rk14       = ks[2][rk_idx14];

    always @(posedge clk) begin
        if (rst_n && bus10.in_valid && bus10.in_ready) acc10 <= acc10 + 1;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.out_ready = 1'b0;
        bus14.in_valid = 1'b0; bus14.in_data = '0; bus14.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus10.out_valid !== 1'b0 || busy10 !== 1'b0 || rk_idx10 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_ctl: ov=%b busy=%b rk_idx=%0d, want 0/0/0",
                     bus10.out_valid, busy10, rk_idx10);
        end
        vectors++;
        if (bus10.out_data !== 128'h0 || rf_state10 !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h, want 0", bus10.out_data);
        end
        vectors++;
        if (bus10.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, want 0", bus10.in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus10.in_ready !== 1'b1 || bus14.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_in_ready: got %b/%b, want 1/1", bus10.in_ready, bus14.in_ready);
        end
    endtask

    task automatic test_fips128_trace();
        sel10 = 0;
        vectors++;
        if (rk_idx10 !== 4'd0) begin
            miscompares++;
            $display("FAIL idle_rk_idx: got %0d, want 0", rk_idx10);
        end
        bus10.in_valid = 1'b1; bus10.in_data = PT_C;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        for (int j = 0; j <= 10; j++) begin
            vectors++;
            if (rk_idx10 !== ((j <= 9) ? 4'(j + 1) : 4'd0)) begin
                miscompares++;
                $display("FAIL rk_trace[%0d]: got %0d, want %0d", j, rk_idx10, (j <= 9) ? j + 1 : 0);
            end
            vectors++;
            if (bus10.out_valid !== (j == 10) || busy10 !== (j <= 9)) begin
                miscompares++;
                $display("FAIL phase[%0d]: ov=%b busy=%b, want %b/%b", j, bus10.out_valid, busy10,
                         j == 10, j <= 9);
            end
            if (j < 10) @(negedge clk);
        end
        vectors++;
        if (bus10.out_data !== CT_C1) begin
            miscompares++;
            $display("FAIL fips_c1: got %h, want %h", bus10.out_data, CT_C1);
        end
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.out_ready = 1'b0;
        vectors++;
        if (bus10.out_valid !== 1'b0 || bus10.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL c1_handshake: ov=%b in_ready=%b, want 0/1", bus10.out_valid, bus10.in_ready);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        a0 = acc10;
        sel10 = 0;
        bus10.in_valid = 1'b1; bus10.in_data = PT_C; bus10.out_ready = 1'b0;
        for (int i = 0; i < 15 && !bus10.out_valid; i++) @(negedge clk);
        vectors++;
        if (bus10.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_timeout: out_valid=%b, want 1", bus10.out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (bus10.out_data !== CT_C1 || bus10.in_ready !== 1'b0 || acc10 !== a0 + 1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: data=%h in_ready=%b accepts=%0d, want %h/0/%0d",
                         k, bus10.out_data, bus10.in_ready, acc10 - a0, CT_C1, 1);
            end
            if (k < 4) @(negedge clk);
        end
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.out_ready = 1'b0;
        vectors++;
        if (bus10.out_valid !== 1'b0 || bus10.in_ready !== 1'b1 || acc10 !== a0 + 1) begin
            miscompares++;
            $display("FAIL bp_bubble: ov=%b in_ready=%b accepts=%0d, want 0/1/1",
                     bus10.out_valid, bus10.in_ready, acc10 - a0);
        end
        @(negedge clk);
        bus10.in_valid = 1'b0;
        vectors++;
        if (acc10 !== a0 + 2 || busy10 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second_accept: accepts=%0d busy=%b, want 2/1", acc10 - a0, busy10);
        end
        for (int i = 0; i < 15 && !bus10.out_valid; i++) @(negedge clk);
        vectors++;
        if (bus10.out_data !== CT_C1 || bus10.out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second_data: ov=%b data=%h, want 1/%h", bus10.out_valid,
                     bus10.out_data, CT_C1);
        end
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic seen_ov;
        seen_ov = 1'b0;
        sel10 = 0;
        bus10.in_valid = 1'b1; bus10.in_data = PT_C;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        for (int i = 0; i < 8 && rk_idx10 != 4'd4; i++) @(negedge clk);
        vectors++;
        if (rk_idx10 !== 4'd4) begin
            miscompares++;
            $display("FAIL mid_reach_round4: rk_idx=%0d, want 4", rk_idx10);
        end
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            seen_ov = seen_ov | bus10.out_valid;
        end
        vectors++;
        if (busy10 !== 1'b0 || rk_idx10 !== 4'd0 || rf_state10 !== 128'h0) begin
            miscompares++;
            $display("FAIL mid_reset_state: busy=%b rk_idx=%0d state=%h, want 0/0/0",
                     busy10, rk_idx10, rf_state10);
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            seen_ov = seen_ov | bus10.out_valid;
        end
        vectors++;
        if (seen_ov !== 1'b0 || bus10.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_no_emit: out_valid_seen=%b in_ready=%b, want 0/1", seen_ov,
                     bus10.in_ready);
        end
        sel10 = 1;
        bus10.in_valid = 1'b1; bus10.in_data = PT_B;
        @(negedge clk);
        bus10.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (bus10.out_valid !== 1'b1 || bus10.out_data !== CT_B) begin
            miscompares++;
            $display("FAIL mid_new_block: ov=%b data=%h, want 1/%h", bus10.out_valid,
                     bus10.out_data, CT_B);
        end
        bus10.out_ready = 1'b1;
        @(negedge clk);
        bus10.out_ready = 1'b0;
    endtask

    task automatic test_nr14();
        bus14.in_valid = 1'b1; bus14.in_data = PT_C;
        @(negedge clk);
        bus14.in_valid = 1'b0;
        for (int j = 0; j <= 14; j++) begin
            vectors++;
            if (rk_idx14 !== ((j <= 13) ? 4'(j + 1) : 4'd0) || bus14.out_valid !== (j == 14)) begin
                miscompares++;
                $display("FAIL nr14_phase[%0d]: rk_idx=%0d ov=%b, want %0d/%b", j, rk_idx14,
                         bus14.out_valid, (j <= 13) ? j + 1 : 0, j == 14);
            end
            if (j < 14) @(negedge clk);
        end
        vectors++;
        if (bus14.out_data !== CT_C3) begin
            miscompares++;
            $display("FAIL fips_c3: got %h, want %h", bus14.out_data, CT_C3);
        end
        bus14.out_ready = 1'b1;
        @(negedge clk);
        bus14.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int     prev, n_acc, n_out;
        int     acc_t [0:1];
        block_t outs [0:1];
        prev = acc10; n_acc = 0; n_out = 0;
        acc_t[0] = 0; acc_t[1] = 0; outs[0] = '0; outs[1] = '0;
        sel10 = 1;
        bus10.out_ready = 1'b1;
        bus10.in_valid = 1'b1; bus10.in_data = PT_B;
        for (int t = 0; t < 40 && n_out < 2; t++) begin
            @(negedge clk);
            if (acc10 != prev && n_acc < 2) begin
                acc_t[n_acc] = t;
                n_acc++;
                prev = acc10;
                if (n_acc == 1) bus10.in_data = PT_C;
                else bus10.in_valid = 1'b0;
            end
            if (bus10.out_valid && n_out < 2) begin
                outs[n_out] = bus10.out_data;
                n_out++;
                if (n_out == 1) sel10 = 0;
            end
        end
        bus10.in_valid = 1'b0;
        bus10.out_ready = 1'b0;
        vectors++;
        if (n_acc !== 2 || n_out !== 2) begin
            miscompares++;
            $display("FAIL b2b_counts: accepts=%0d outputs=%0d, want 2/2", n_acc, n_out);
        end
        vectors++;
        if (acc_t[1] - acc_t[0] !== 12) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d, want 12", acc_t[1] - acc_t[0]);
        end
        vectors++;
        if (outs[0] !== CT_B || outs[1] !== CT_C1) begin
            miscompares++;
            $display("FAIL b2b_data: got %h %h, want %h %h", outs[0], outs[1], CT_B, CT_C1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
        expand(0, KEY_C1, 4, 10);
        expand(1, KEY_B, 4, 10);
        expand(2, KEY_C3, 8, 14);
        test_reset();
        test_fips128_trace();
        test_backpressure();
        test_reset_mid();
        test_nr14();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
